c2h_q_sched: RTL

- Multi-queue scheduler for the C2H streaming packet generator.
- Tracks per-queue descriptor credits and packet quotas, and picks one eligible queue at a time by round-robin.
- Grants that queue to the generator, then holds the grant until the packet's tlast beat completes on the C2H AXI-Stream.
- Sits between the credit/control register path and the generator. Turns a single-queue generator into a shared NUM_Q-queue resource.

---
 rtl/c2h_sched_pkg.sv | 22 ++
 rtl/c2h_rr_pick.sv | 26 ++
 rtl/c2h_q_sched.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/c2h_sched_pkg.sv
// Shared types and default widths for the C2H multi-queue scheduler.
package c2h_sched_pkg;

  localparam int NUM_Q_D       = 4;
  localparam int QID_W_D       = 2;
  localparam int TM_DSC_BITS_D = 16;
  localparam int PKT_W_D       = 11;
  localparam int WDOG_CYC_D    = 4096;

  typedef enum logic [1:0] {
    S_ARB   = 2'd0,
    S_GRANT = 2'd1,
    S_XFER  = 2'd2
  } state_e;

  typedef struct packed {
    logic [TM_DSC_BITS_D-1:0] credit;
    logic [PKT_W_D-1:0]       quota;
    logic [PKT_W_D-1:0]       sent;
  } q_state_t;

endpackage

// File: rtl/c2h_rr_pick.sv
// Rotate-priority encoder: first eligible queue at or above rr_ptr, with wrap.
module c2h_rr_pick
  import c2h_sched_pkg::*;
#(
  parameter int NUM_Q = NUM_Q_D,
  parameter int QID_W = QID_W_D
) (
  input  logic [NUM_Q-1:0] eligible,
  input  logic [QID_W-1:0] rr_ptr,
  output logic             found,
  output logic [QID_W-1:0] qid
);

  // Walk from the farthest offset down so the nearest eligible queue wins.
  always_comb begin
    found = 1'b0;
    qid   = rr_ptr;
    for (int i = NUM_Q - 1; i >= 0; i--) begin
      if (eligible[rr_ptr + QID_W'(i)]) begin
        found = 1'b1;
        qid   = rr_ptr + QID_W'(i);
      end
    end
  end

endmodule

// File: rtl/c2h_q_sched.sv
// Credit/quota-gated round-robin queue scheduler for the C2H packet generator.
// Optional packet watchdog is built only when C2H_SCHED_WDOG_EN is defined.
module c2h_q_sched
  import c2h_sched_pkg::*;
#(
  parameter int NUM_Q       = NUM_Q_D,
  parameter int QID_W       = QID_W_D,
  parameter int TM_DSC_BITS = TM_DSC_BITS_D,
  parameter int PKT_W       = PKT_W_D,
  parameter int WDOG_CYC    = WDOG_CYC_D
) (
  input  logic                   axi_aclk,
  input  logic                   axi_areset,
  input  logic                   cfg_wr,
  input  logic [QID_W-1:0]       cfg_qid,
  input  logic [PKT_W-1:0]       cfg_num_pkt,
  input  logic                   credit_updt,
  input  logic [QID_W-1:0]       credit_qid,
  input  logic [TM_DSC_BITS-1:0] credit_in,
  output logic                   sel_valid,
  output logic [QID_W-1:0]       sel_qid,
  input  logic                   sel_ready,
  input  logic                   c2h_tvalid,
  input  logic                   c2h_tready,
  input  logic                   c2h_tlast,
  output logic [NUM_Q-1:0]       q_active,
  output logic [NUM_Q-1:0]       q_done,
  output logic                   cfg_err,
  output logic                   wdog_err
);

  state_e                 state_q, state_d;
  logic [TM_DSC_BITS-1:0] credit_q [NUM_Q];
  logic [TM_DSC_BITS-1:0] credit_d [NUM_Q];
  logic [TM_DSC_BITS:0]   credit_net [NUM_Q];
  logic [PKT_W-1:0]       quota_q [NUM_Q];
  logic [PKT_W-1:0]       quota_d [NUM_Q];
  logic [PKT_W-1:0]       sent_q [NUM_Q];
  logic [PKT_W-1:0]       sent_d [NUM_Q];
  logic [QID_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [QID_W-1:0]       sel_qid_q, sel_qid_d;
  logic                   sel_valid_q, sel_valid_d;
  logic [NUM_Q-1:0]       q_active_q, q_active_d;
  logic [NUM_Q-1:0]       q_done_q, q_done_d;
  logic                   cfg_err_q, cfg_err_d;
  logic [NUM_Q-1:0]       eligible;
  logic                   pick_found;
  logic [QID_W-1:0]       pick_qid;
  logic                   accept, beat;

`ifdef C2H_SCHED_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYC);
  logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
  logic              wdog_err_q, wdog_err_d;
`endif

  assign accept = (state_q == S_GRANT) & sel_valid_q & sel_ready;
  assign beat   = (state_q == S_XFER) & c2h_tvalid & c2h_tready & c2h_tlast;

  always_comb begin
    for (int q = 0; q < NUM_Q; q++) begin
      eligible[q] = (quota_q[q] != '0) && (sent_q[q] < quota_q[q]) && (credit_q[q] != '0);
    end
  end

  c2h_rr_pick #(.NUM_Q(NUM_Q), .QID_W(QID_W)) u_pick (
    .eligible (eligible),
    .rr_ptr   (rr_ptr_q),
    .found    (pick_found),
    .qid      (pick_qid)
  );

  // One extra bit holds add-then-debit so saturation happens once on the net result.
  always_comb begin
    for (int q = 0; q < NUM_Q; q++) begin
      credit_net[q] = {1'b0, credit_q[q]};
      if (credit_updt && (credit_qid == QID_W'(q)))
        credit_net[q] = credit_net[q] + {1'b0, credit_in};
      if (accept && (sel_qid_q == QID_W'(q)))
        credit_net[q] = credit_net[q] - {{TM_DSC_BITS{1'b0}}, 1'b1};
      credit_d[q] = credit_net[q][TM_DSC_BITS] ? '1 : credit_net[q][TM_DSC_BITS-1:0];
    end
  end

  // S_ARB   | scanning for the next eligible queue
  // S_GRANT | grant offered, waiting for sel_ready
  // S_XFER  | packet in flight, waiting for its tlast beat
  always_comb begin
    state_d     = state_q;
    sel_valid_d = sel_valid_q;
    sel_qid_d   = sel_qid_q;
    rr_ptr_d    = rr_ptr_q;
    q_active_d  = q_active_q;
    q_done_d    = '0;
    cfg_err_d   = 1'b0;
    quota_d     = quota_q;
    sent_d      = sent_q;
`ifdef C2H_SCHED_WDOG_EN
    wdog_cnt_d  = wdog_cnt_q;
    wdog_err_d  = 1'b0;
`endif

    if (cfg_wr) begin
      if ((state_q != S_ARB) && (cfg_qid == sel_qid_q)) begin
        cfg_err_d = 1'b1;
      end else begin
        quota_d[cfg_qid] = cfg_num_pkt;
        sent_d[cfg_qid]  = '0;
      end
    end

    case (state_q)
      S_ARB: begin
        if (pick_found) begin
          sel_valid_d = 1'b1;
          sel_qid_d   = pick_qid;
          q_active_d  = NUM_Q'(1) << pick_qid;
          state_d     = S_GRANT;
        end
      end
      S_GRANT: begin
        if (accept) begin
          sel_valid_d = 1'b0;
          rr_ptr_d    = sel_qid_q + QID_W'(1);
          state_d     = S_XFER;
`ifdef C2H_SCHED_WDOG_EN
          wdog_cnt_d  = '0;
`endif
        end
      end
      S_XFER: begin
        if (beat) begin
          sent_d[sel_qid_q]   = sent_q[sel_qid_q] + PKT_W'(1);
          q_done_d[sel_qid_q] = ((sent_q[sel_qid_q] + PKT_W'(1)) == quota_q[sel_qid_q]);
          q_active_d          = '0;
          state_d             = S_ARB;
        end
`ifdef C2H_SCHED_WDOG_EN
        else if (wdog_cnt_q == WDOG_W'(WDOG_CYC - 1)) begin
          wdog_err_d = 1'b1;
          q_active_d = '0;
          state_d    = S_ARB;
        end else begin
          wdog_cnt_d = wdog_cnt_q + WDOG_W'(1);
        end
`endif
      end
      default: state_d = S_ARB;
    endcase
  end

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      state_q     <= S_ARB;
      rr_ptr_q    <= '0;
      sel_qid_q   <= '0;
      sel_valid_q <= 1'b0;
      q_active_q  <= '0;
      q_done_q    <= '0;
      cfg_err_q   <= 1'b0;
      for (int q = 0; q < NUM_Q; q++) begin
        credit_q[q] <= '0;
        quota_q[q]  <= '0;
        sent_q[q]   <= '0;
      end
`ifdef C2H_SCHED_WDOG_EN
      wdog_cnt_q  <= '0;
      wdog_err_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      sel_qid_q   <= sel_qid_d;
      sel_valid_q <= sel_valid_d;
      q_active_q  <= q_active_d;
      q_done_q    <= q_done_d;
      cfg_err_q   <= cfg_err_d;
      credit_q    <= credit_d;
      quota_q     <= quota_d;
      sent_q      <= sent_d;
`ifdef C2H_SCHED_WDOG_EN
      wdog_cnt_q  <= wdog_cnt_d;
      wdog_err_q  <= wdog_err_d;
`endif
    end
  end

  assign sel_valid = sel_valid_q;
  assign sel_qid   = sel_qid_q;
  assign q_active  = q_active_q;
  assign q_done    = q_done_q;
  assign cfg_err   = cfg_err_q;
`ifdef C2H_SCHED_WDOG_EN
  assign wdog_err  = wdog_err_q;
`else
  assign wdog_err  = 1'b0;
`endif

endmodule
